fc1_seq: RTL and testbench

FC1_SEQ -- requirements
Module: fc1_seq

---
 rtl/fc1_seq.sv | 144 ++++++++++++++
 tb/tb_fc1_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fc1_seq.sv
// FC1 layer sequencer: streams one weight word per input index for each group of
// NUM_PE neurons, drives the PE datapath controls and hands each group to a consumer.
module fc1_seq #(
  parameter int IN1_N  = 132,
  parameter int OUT1_M = 10,
  parameter int NUM_PE = 4,
  parameter int ADDR_W = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_gnt,
  input  logic [8*NUM_PE-1:0]          mem_rdata,
  output logic                         dp_clr,
  output logic                         dp_acc,
  output logic [$clog2(IN1_N)-1:0]     dp_x_idx,
  output logic [8*NUM_PE-1:0]          dp_w,
  output logic                         dp_cap,
  output logic [$clog2(OUT1_M):0]      dp_base,
  output logic [NUM_PE-1:0]            dp_mask,
  output logic                         grp_valid,
  input  logic                         grp_next
);

  localparam int IDX_W  = $clog2(IN1_N);
  localparam int BASE_W = $clog2(OUT1_M) + 1;
  localparam int G      = (OUT1_M + NUM_PE - 1) / NUM_PE;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(IN1_N - 1);
  localparam logic [BASE_W-1:0] GRP_LAST = BASE_W'(G - 1);
  localparam logic [BASE_W-1:0] BASE_STEP = BASE_W'(NUM_PE);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, CAPTURE, WAIT} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [BASE_W-1:0] group;

  function automatic logic [NUM_PE-1:0] lane_mask(input logic [BASE_W-1:0] base);
    logic [NUM_PE-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      m[k] = (int'(base) + k) < OUT1_M;
    end
    return m;
  endfunction

  // mem_addr simply keeps counting across groups: the word after the last one of
  // group g is the first one of group g+1, so no multiply is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      group     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      dp_clr    <= 1'b0;
      dp_acc    <= 1'b0;
      dp_x_idx  <= '0;
      dp_cap    <= 1'b0;
      dp_base   <= '0;
      dp_mask   <= '0;
      grp_valid <= 1'b0;
    end else begin
      dp_clr <= 1'b0;
      dp_acc <= 1'b0;
      dp_cap <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            group    <= '0;
            dp_base  <= '0;
            dp_mask  <= lane_mask('0);
            mem_addr <= '0;
            busy     <= 1'b1;
            dp_clr   <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          idx     <= '0;
          mem_req <= 1'b1;
          state   <= STREAM;
        end
        STREAM: begin
          if (mem_gnt) begin
            dp_acc   <= 1'b1;
            dp_x_idx <= idx;
            mem_addr <= mem_addr + ADDR_W'(1);
            if (idx == IDX_LAST) begin
              mem_req <= 1'b0;
              state   <= DRAIN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          dp_cap <= 1'b1;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          grp_valid <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (grp_next) begin
            grp_valid <= 1'b0;
            if (group == GRP_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              group   <= group + BASE_W'(1);
              dp_base <= dp_base + BASE_STEP;
              dp_mask <= lane_mask(dp_base + BASE_STEP);
              dp_clr  <= 1'b1;
              state   <= CLEAR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lands the cycle after the grant, together with dp_acc.
  always_comb begin
    dp_w = '0;
    if (dp_acc) begin
      for (int k = 0; k < NUM_PE; k++) begin
        if (dp_mask[k]) dp_w[8*k +: 8] = mem_rdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fc1_seq.sv
// Directed bench for fc1_seq: nominal job, memory stall, ignored inputs,
// last-group lane masking and mid-job reset.
module tb_fc1_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_gnt = 1'b1;
  logic        grp_next = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, done, mem_req, dp_clr, dp_acc, dp_cap, grp_valid;
  logic [11:0] mem_addr;
  logic [7:0]  dp_x_idx;
  logic [31:0] dp_w;
  logic [4:0]  dp_base;
  logic [3:0]  dp_mask;

  logic [11:0] gaddr = '0;
  logic        clear_stats = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0, clr_cyc = 0, n_clr = 0, grp_i = 0, acc_cnt = 0, exp_idx = 0;
  int seq_err = 0, w_err = 0, n_cap = 0, n_done = 0;
  int cap_base [8];
  int cap_mask [8];
  int cap_acc  [8];
  int cap_lat  [8];

  fc1_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .dp_clr(dp_clr), .dp_acc(dp_acc), .dp_x_idx(dp_x_idx), .dp_w(dp_w),
    .dp_cap(dp_cap), .dp_base(dp_base), .dp_mask(dp_mask),
    .grp_valid(grp_valid), .grp_next(grp_next)
  );

  always #5 clk = ~clk;

  // Weight memory model: lane k of word a is a+k, except the last group (a >= 264) is all 0x7F.
  function automatic logic [31:0] rdata_of(input logic [11:0] a);
    if (a >= 12'd264) return {4{8'h7F}};
    return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      mem_rdata <= rdata_of(mem_addr);
      gaddr     <= mem_addr;
    end
  end

  // Passive monitor: per-group accumulate count, index sequence, weight lanes, captures.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clear_stats) begin
      n_clr <= 0; acc_cnt <= 0; exp_idx <= 0; seq_err <= 0; w_err <= 0;
      n_cap <= 0; n_done <= 0; grp_i <= 0;
    end else if (rst_n) begin
      if (dp_clr) begin
        grp_i   <= n_clr;
        n_clr   <= n_clr + 1;
        clr_cyc <= cyc;
        acc_cnt <= 0;
        exp_idx <= 0;
      end
      if (dp_acc) begin
        if (int'(dp_x_idx) != exp_idx) seq_err <= seq_err + 1;
        if (dp_w !== (rdata_of(gaddr) & lanes(grp_i < 2 ? 4'hF : 4'h3))) w_err <= w_err + 1;
        exp_idx <= exp_idx + 1;
        acc_cnt <= acc_cnt + 1;
      end
      if (dp_cap && n_cap < 8) begin
        cap_base[n_cap] <= int'(dp_base);
        cap_mask[n_cap] <= int'(dp_mask);
        cap_acc[n_cap]  <= acc_cnt;
        cap_lat[n_cap]  <= cyc - clr_cyc + 1;
        n_cap <= n_cap + 1;
      end
      if (done) n_done <= n_done + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({busy, done, mem_req, dp_clr, dp_acc, dp_cap, grp_valid}), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_dp"}, 32'({dp_x_idx, dp_base, dp_mask}), 32'd0);
    check({tag, "_w"}, dp_w, 32'd0);
  endtask

  task automatic reset_stats();
    clear_stats = 1'b1;
    @(posedge clk);
    @(posedge clk);
    clear_stats = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for grp_valid, acknowledges it two cycles later with a one-cycle grp_next.
  task automatic ack_group(input string tag);
    for (int i = 0; i < 800 && !grp_valid; i++) @(negedge clk);
    check({tag, "_grp_valid"}, 32'(grp_valid), 32'd1);
    repeat (2) @(negedge clk);
    grp_next = 1'b1;
    @(negedge clk);
    grp_next = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    reset_stats();

    // Nominal job with stray start/grp_next during STREAM.
    pulse_start();
    check("clear_state", 32'({busy, dp_clr, mem_req}), 32'b110);
    for (int i = 0; i < 400 && !(mem_req && mem_addr == 12'd20); i++) @(negedge clk);
    check("reach_addr20", 32'(mem_addr), 32'd20);
    start    = 1'b1;
    grp_next = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    grp_next = 1'b0;
    check("stream_ignore", 32'({busy, mem_req, dp_clr, grp_valid, mem_addr}), {16'd0, 4'b1100, 12'd21});
    ack_group("a_g0");
    ack_group("a_g1");
    for (int i = 0; i < 400 && !(dp_acc && dp_base == 5'd8); i++) @(negedge clk);
    check("last_grp_dp_w", dp_w, 32'h00007F7F);
    ack_group("a_g2");
    check("done_pulse", 32'({done, busy}), 32'b10);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("a_n_cap", 32'(n_cap), 32'd3);
    check("a_bases", 32'({8'(cap_base[0]), 8'(cap_base[1]), 8'(cap_base[2])}), 32'h000408);
    check("a_masks", 32'({4'(cap_mask[0]), 4'(cap_mask[1]), 4'(cap_mask[2])}), 32'hFF3);
    check("a_latency", 32'(cap_lat[0]), 32'd135);
    check("a_acc_cnt", 32'({8'(cap_acc[0]), 8'(cap_acc[1]), 8'(cap_acc[2])}), {8'd0, 8'd132, 8'd132, 8'd132});
    check("a_seq_err", 32'(seq_err), 32'd0);
    check("a_w_err", 32'(w_err), 32'd0);
    check("a_n_done", 32'(n_done), 32'd1);

    // Five-cycle memory stall at idx 50 of group 0.
    reset_stats();
    pulse_start();
    for (int i = 0; i < 400 && !(mem_req && mem_addr == 12'd50); i++) @(negedge clk);
    check("reach_addr50", 32'(mem_addr), 32'd50);
    mem_gnt = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_hold", 32'({mem_req, dp_acc, mem_addr}), {19'd0, 1'b1, 1'b0, 12'd50});
    end
    mem_gnt = 1'b1;
    ack_group("b_g0");
    ack_group("b_g1");
    ack_group("b_g2");
    repeat (3) @(negedge clk);
    check("b_acc_cnt", 32'({8'(cap_acc[0]), 8'(cap_acc[1]), 8'(cap_acc[2])}), {8'd0, 8'd132, 8'd132, 8'd132});
    check("b_seq_err", 32'(seq_err), 32'd0);
    check("b_latency_stall", 32'(cap_lat[0]), 32'd140);
    check("b_latency_free", 32'(cap_lat[1]), 32'd135);
    check("b_n_done", 32'(n_done), 32'd1);

    // Reset mid-job at group 1, idx 70, then restart.
    reset_stats();
    pulse_start();
    ack_group("c_g0");
    for (int i = 0; i < 400 && !(mem_req && mem_addr == 12'd202); i++) @(negedge clk);
    check("reach_g1_idx70", 32'({dp_base, mem_addr}), {15'd0, 5'd4, 12'd202});
    rst_n = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("c_no_cap_done", 32'({8'(n_cap), 8'(n_done)}), 32'h0100);
    check("c_idle", 32'({busy, mem_req}), 32'd0);
    pulse_start();
    @(negedge clk);
    check("restart", 32'({mem_req, dp_mask, dp_base, mem_addr}), {10'd0, 1'b1, 4'hF, 5'd0, 12'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
